// File: rtl/rr_priority_encoder_pkg.sv
// Shared definitions for the round-robin priority encoder slice:
// mode encoding, legal request-width range and the pointer wrap helper.
package rr_priority_encoder_pkg;

  // Search mode sampled with each accepted request vector.
  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } rrModeE;

  // Legal range for the number of request lines.
  localparam int MIN_N = 2;
  localparam int MAX_N = 64;

  // Advance an index by one, wrapping N-1 back to 0 so that a pointer
  // never takes a value outside 0..N-1, even when N is not a power of two.
  function automatic int wrapInc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// Combinational masked search: returns the first set bit of vec_i at or
// above start_i, wrapping around to the lowest set bit when nothing is set
// in the upper region. A start of 0 degenerates to a plain lowest-bit search.
module rr_find_first #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  input  logic [W-1:0] start_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [N-1:0] upperMask;
  logic [N-1:0] upperReq;
  logic [W-1:0] upperIdx;
  logic         upperHit;
  logic [W-1:0] lowIdx;
  logic         anyHit;

  // Build a mask covering bit positions at or above the start pointer.
  always_comb begin
    upperMask = '0;
    for (int i = 0; i < N; i++) begin
      upperMask[i] = (i >= int'(start_i));
    end
  end

  assign upperReq = vec_i & upperMask;

  // Lowest set bit inside the masked (upper) region; scanning downward lets
  // the last hit, i.e. the lowest index, win.
  always_comb begin
    upperHit = 1'b0;
    upperIdx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (upperReq[i]) begin
        upperHit = 1'b1;
        upperIdx = W'(i);
      end
    end
  end

  // Lowest set bit of the whole vector, used when the search wraps.
  always_comb begin
    anyHit = 1'b0;
    lowIdx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        anyHit = 1'b1;
        lowIdx = W'(i);
      end
    end
  end

  // Prefer the upper region; lowIdx is already 0 when the vector is empty.
  always_comb begin
    found_o = anyHit;
    idx_o   = upperHit ? upperIdx : lowIdx;
  end

endmodule

// File: rtl/rr_priority_encoder.sv
// Priority encoder with fixed and round-robin modes behind a single
// valid/ready output register. Also flags all-zero and multi-hot vectors
// and keeps a saturating count of multi-hot vectors accepted.
module rr_priority_encoder
  import rr_priority_encoder_pkg::*;
#(
  parameter int N     = 8,
  parameter int W     = $clog2(N),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     req,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_idx,
  output logic             out_zero,
  output logic             out_multi,
  output logic [CNT_W-1:0] multi_cnt
);

  logic             outValid_q, outValid_d;
  logic [W-1:0]     outIdx_q,   outIdx_d;
  logic             outZero_q,  outZero_d;
  logic             outMulti_q, outMulti_d;
  logic [CNT_W-1:0] multiCnt_q, multiCnt_d;
  logic [W-1:0]     rrPtr_q,    rrPtr_d;

  logic             accept;
  logic             rrMode;
  logic [W-1:0]     searchStart;
  logic [W-1:0]     foundIdx;
  logic             found;
  logic [W-1:0]     winIdx;
  logic             reqZero;
  logic             reqMulti;

  // The single output slot can take a new vector whenever it is empty or
  // being drained in the same cycle, which gives full throughput.
  assign in_ready = !outValid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Fixed mode is just a round-robin search that always starts at bit 0,
  // so one search instance serves both modes.
  always_comb begin
    rrMode      = (mode == MODE_RR);
    searchStart = rrMode ? rrPtr_q : '0;
  end

  rr_find_first #(
    .N (N),
    .W (W)
  ) u_find (
    .vec_i   (req),
    .start_i (searchStart),
    .idx_o   (foundIdx),
    .found_o (found)
  );

  // Classify the incoming vector: empty, or two or more bits set
  // (clearing the lowest set bit leaves something behind).
  always_comb begin
    reqZero  = ~|req;
    reqMulti = |(req & (req - N'(1)));
    winIdx   = found ? foundIdx : '0;
  end

  // Next-state for the output register, rotation pointer and counter.
  always_comb begin
    outValid_d = outValid_q;
    outIdx_d   = outIdx_q;
    outZero_d  = outZero_q;
    outMulti_d = outMulti_q;
    multiCnt_d = multiCnt_q;
    rrPtr_d    = rrPtr_q;

    if (accept) begin
      outValid_d = 1'b1;
      outIdx_d   = winIdx;
      outZero_d  = reqZero;
      outMulti_d = reqMulti;

      if (reqMulti && (multiCnt_q != {CNT_W{1'b1}})) begin
        multiCnt_d = multiCnt_q + CNT_W'(1);
      end

      if (rrMode && !reqZero) begin
        rrPtr_d = W'(wrapInc(int'(winIdx), N));
      end
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // State registers; reset clears any held result and the rotation state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q <= 1'b0;
      outIdx_q   <= '0;
      outZero_q  <= 1'b0;
      outMulti_q <= 1'b0;
      multiCnt_q <= '0;
      rrPtr_q    <= '0;
    end else begin
      outValid_q <= outValid_d;
      outIdx_q   <= outIdx_d;
      outZero_q  <= outZero_d;
      outMulti_q <= outMulti_d;
      multiCnt_q <= multiCnt_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_idx   = outIdx_q;
  assign out_zero  = outZero_q;
  assign out_multi = outMulti_q;
  assign multi_cnt = multiCnt_q;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Scoreboard bench for rr_priority_encoder: an N=8 instance (A) for the main
// behaviour and an N=5, CNT_W=2 instance (B) for non-power-of-two wrap and
// counter saturation. Expected results are queued at acceptance and checked
// by per-instance monitors whenever the output register holds a result.
`timescale 1ns/1ps
module tb_rr_priority_encoder;

  logic       clk;
  logic       rst_n;

  logic       aInValid, aInReady, aMode, aOutValid, aOutReady, aOutZero, aOutMulti;
  logic [7:0] aReq;
  logic [2:0] aOutIdx;
  logic [7:0] aMultiCnt;

  logic       bInValid, bInReady, bMode, bOutValid, bOutReady, bOutZero, bOutMulti;
  logic [4:0] bReq;
  logic [2:0] bOutIdx;
  logic [1:0] bMultiCnt;

  typedef struct packed {
    logic [2:0] idx;
    logic       zero;
    logic       multi;
    logic [7:0] cnt;
  } expT;

  expT qA[$];
  expT qB[$];

  int assertCount = 0;
  int failCount   = 0;

  rr_priority_encoder #(.N(8), .CNT_W(8)) dutA (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (aInValid),
    .in_ready  (aInReady),
    .req       (aReq),
    .mode      (aMode),
    .out_valid (aOutValid),
    .out_ready (aOutReady),
    .out_idx   (aOutIdx),
    .out_zero  (aOutZero),
    .out_multi (aOutMulti),
    .multi_cnt (aMultiCnt)
  );

  rr_priority_encoder #(.N(5), .CNT_W(2)) dutB (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bInValid),
    .in_ready  (bInReady),
    .req       (bReq),
    .mode      (bMode),
    .out_valid (bOutValid),
    .out_ready (bOutReady),
    .out_idx   (bOutIdx),
    .out_zero  (bOutZero),
    .out_multi (bOutMulti),
    .multi_cnt (bMultiCnt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor for instance A: held results must match the queue head every
  // cycle they are visible; the head is retired when the sink consumes it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && aOutValid === 1'b1) begin
      if (qA.size() == 0) begin
        checkOutput("A_unexpected_valid", {7'd0, aOutValid}, 8'd0);
      end else begin
        checkOutput("A_idx",   {5'd0, aOutIdx},   {5'd0, qA[0].idx});
        checkOutput("A_zero",  {7'd0, aOutZero},  {7'd0, qA[0].zero});
        checkOutput("A_multi", {7'd0, aOutMulti}, {7'd0, qA[0].multi});
        checkOutput("A_cnt",   aMultiCnt,         qA[0].cnt);
        if (aOutReady) void'(qA.pop_front());
      end
    end
  end

  // Monitor for instance B, same scheme.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bOutValid === 1'b1) begin
      if (qB.size() == 0) begin
        checkOutput("B_unexpected_valid", {7'd0, bOutValid}, 8'd0);
      end else begin
        checkOutput("B_idx",   {5'd0, bOutIdx},   {5'd0, qB[0].idx});
        checkOutput("B_zero",  {7'd0, bOutZero},  {7'd0, qB[0].zero});
        checkOutput("B_multi", {7'd0, bOutMulti}, {7'd0, qB[0].multi});
        checkOutput("B_cnt",   {6'd0, bMultiCnt}, qB[0].cnt);
        if (bOutReady) void'(qB.pop_front());
      end
    end
  end

  // Present one vector to instance sel, wait (bounded) for acceptance and
  // queue the hand-computed result. Returns 1 time unit after the edge.
  task automatic applyStimulus(input int sel, input logic mode, input logic [7:0] req,
                               input logic [2:0] expIdx, input logic expZero,
                               input logic expMulti, input logic [7:0] expCnt);
    int   budget;
    logic ready;
    expT  e;
    budget  = 0;
    e.idx   = expIdx;
    e.zero  = expZero;
    e.multi = expMulti;
    e.cnt   = expCnt;
    if (sel == 0) begin
      aInValid = 1'b1; aMode = mode; aReq = req;
    end else begin
      bInValid = 1'b1; bMode = mode; bReq = req[4:0];
    end
    @(negedge clk);
    ready = (sel == 0) ? aInReady : bInReady;
    while (ready !== 1'b1 && budget < 20) begin
      budget++;
      @(negedge clk);
      ready = (sel == 0) ? aInReady : bInReady;
    end
    if (ready !== 1'b1) begin
      checkOutput((sel == 0) ? "A_accept_timeout" : "B_accept_timeout", {7'd0, ready}, 8'd1);
    end else if (sel == 0) begin
      qA.push_back(e);
    end else begin
      qB.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    aInValid = 1'b0;
    bInValid = 1'b0;
  endtask

  // Wait (bounded) until every queued result has been seen and consumed.
  task automatic waitDrain();
    int budget;
    budget = 0;
    while ((qA.size() != 0 || qB.size() != 0) && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    checkOutput("drain_pending", 8'(qA.size() + qB.size()), 8'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b1;
    aInValid = 1'b0; aMode = 1'b0; aReq = '0; aOutReady = 1'b1;
    bInValid = 1'b0; bMode = 1'b0; bReq = '0; bOutReady = 1'b1;

    // Reset values while reset is held.
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_out_valid", {7'd0, aOutValid}, 8'd0);
    checkOutput("rst_out_idx",   {5'd0, aOutIdx},   8'd0);
    checkOutput("rst_out_zero",  {7'd0, aOutZero},  8'd0);
    checkOutput("rst_out_multi", {7'd0, aOutMulti}, 8'd0);
    checkOutput("rst_multi_cnt", aMultiCnt,         8'd0);
    checkOutput("rst_in_ready",  {7'd0, aInReady},  8'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", {7'd0, aInReady}, 8'd1);
    $display("[TB] reset checks done");

    // Fixed priority: lowest index wins.
    applyStimulus(0, 1'b0, 8'b0010_0100, 3'd2, 1'b0, 1'b1, 8'd1);
    applyStimulus(0, 1'b0, 8'b1000_0000, 3'd7, 1'b0, 1'b0, 8'd1);

    // Round-robin, full vector, back-to-back: rotates 0..7 then wraps.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1'b1, 8'hFF, 3'(k % 8), 1'b0, 1'b1, 8'(2 + k));
      checkOutput("A_in_ready_b2b", {7'd0, aInReady}, 8'd1);
    end
    idleInputs();
    waitDrain();
    $display("[TB] back-to-back round-robin done");

    // All-zero vector under backpressure: held stable, no new acceptance.
    aOutReady = 1'b0;
    applyStimulus(0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 8'd11);
    idleInputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("A_stall_in_ready", {7'd0, aInReady},  8'd0);
      checkOutput("A_stall_valid",    {7'd0, aOutValid}, 8'd1);
    end
    @(posedge clk);
    #1;
    aOutReady = 1'b1;
    waitDrain();

    // Pointer held at 2 through the zero vector; inputs wiggle during a
    // stall and must not disturb the registered result.
    aOutReady = 1'b0;
    applyStimulus(0, 1'b1, 8'b0000_0110, 3'd2, 1'b0, 1'b1, 8'd12);
    idleInputs();
    for (int k = 0; k < 2; k++) begin
      aMode = 1'b0;
      aReq  = 8'hF0;
      @(negedge clk);
      checkOutput("A_stall2_in_ready", {7'd0, aInReady}, 8'd0);
      @(posedge clk);
      #1;
    end
    aOutReady = 1'b1;
    waitDrain();

    // Wrap search, fixed-mode transfers leave the pointer alone.
    applyStimulus(0, 1'b1, 8'b0000_0011, 3'd0, 1'b0, 1'b1, 8'd13);
    applyStimulus(0, 1'b0, 8'b0000_1000, 3'd3, 1'b0, 1'b0, 8'd13);
    applyStimulus(0, 1'b1, 8'b1000_0011, 3'd1, 1'b0, 1'b1, 8'd14);
    applyStimulus(0, 1'b0, 8'b1111_0000, 3'd4, 1'b0, 1'b1, 8'd15);
    applyStimulus(0, 1'b1, 8'b0000_0100, 3'd2, 1'b0, 1'b0, 8'd15);
    idleInputs();
    waitDrain();
    $display("[TB] mode mixing done");

    // N=5 instance: non-power-of-two wrap and 2-bit saturating counter.
    applyStimulus(1, 1'b1, 8'b0000_1000, 3'd3, 1'b0, 1'b0, 8'd0);
    applyStimulus(1, 1'b1, 8'b0000_0011, 3'd0, 1'b0, 1'b1, 8'd1);
    applyStimulus(1, 1'b1, 8'b0000_0011, 3'd1, 1'b0, 1'b1, 8'd2);
    applyStimulus(1, 1'b1, 8'b0001_1000, 3'd3, 1'b0, 1'b1, 8'd3);
    applyStimulus(1, 1'b1, 8'b0001_0001, 3'd4, 1'b0, 1'b1, 8'd3);
    applyStimulus(1, 1'b1, 8'b0000_0110, 3'd1, 1'b0, 1'b1, 8'd3);
    applyStimulus(1, 1'b1, 8'b0001_0000, 3'd4, 1'b0, 1'b0, 8'd3);
    applyStimulus(1, 1'b1, 8'b0001_1111, 3'd0, 1'b0, 1'b1, 8'd3);
    idleInputs();
    waitDrain();
    $display("[TB] N=5 wrap and saturation done");

    // Reset while a result is held: cleared asynchronously before any edge.
    aOutReady = 1'b0;
    applyStimulus(0, 1'b1, 8'b0000_0001, 3'd0, 1'b0, 1'b0, 8'd15);
    idleInputs();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    qA.delete();
    qB.delete();
    #1;
    checkOutput("async_rst_out_valid", {7'd0, aOutValid}, 8'd0);
    checkOutput("async_rst_multi_cnt", aMultiCnt,         8'd0);
    checkOutput("async_rst_out_idx",   {5'd0, aOutIdx},   8'd0);
    checkOutput("async_rst_in_ready",  {7'd0, aInReady},  8'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    aOutReady = 1'b1;
    // Pointer was 1 before reset; a cleared pointer picks bit 0.
    applyStimulus(0, 1'b1, 8'hFF, 3'd0, 1'b0, 1'b1, 8'd1);
    idleInputs();
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rr_priority_encoder.md
RR_PRIORITY_ENCODER -- requirements
Module: rr_priority_encoder

Interface
REQ-001 Parameter N, default 8: number of request lines; legal range 2..64.
REQ-002 Parameter W, default $clog2(N): index width; derived from N, never overridden.
REQ-003 Parameter CNT_W, default 8: width of the multi-hot event counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  req vector is presented.
REQ-007 in_ready  output  1  block accepts req this cycle.
REQ-008 req  input  N  request vector; any bit pattern is legal.
REQ-009 mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
REQ-010 out_valid  output  1  out_* fields hold a result.
REQ-011 out_ready  input  1  downstream consumes the result.
REQ-012 out_idx  output  W  index of the winning request bit.
REQ-013 out_zero  output  1  accepted req was all-zero; out_idx is then 0.
REQ-014 out_multi  output  1  accepted req had more than one bit set.
REQ-015 multi_cnt  output  CNT_W  saturating count of accepted multi-hot vectors.

Function
REQ-016 The block SHALL accept a vector when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, one output register, no bubble under full throughput).
REQ-017 The result SHALL appear on out_* one cycle after acceptance and SHALL hold stable while out_valid && !out_ready.
REQ-018 out_valid SHALL rise on acceptance, and SHALL fall when out_ready is high with no new acceptance in the same cycle.
REQ-019 Fixed mode: out_idx = lowest set bit index of req.
REQ-020 Round-robin mode: out_idx = first set bit at or above rr_ptr, searching upward modulo N; wrap from N-1 to 0.
REQ-021 rr_ptr (W bits, internal) SHALL update to (out_idx+1) mod N on every accepted non-zero vector in round-robin mode; it SHALL hold on zero vectors, on fixed-mode transfers, and when idle.
REQ-022 For N not a power of two, the rr_ptr increment SHALL wrap N-1 -> 0, never reaching values >= N.
REQ-023 An all-zero req SHALL be accepted and produce out_zero=1, out_idx=0, out_multi=0.
REQ-024 out_multi = 1 iff popcount(req) >= 2; single-hot input SHALL give out_multi=0 in both modes.
REQ-025 multi_cnt SHALL increment by 1 on each accepted multi-hot vector and saturate at 2^CNT_W-1.
REQ-026 mode SHALL be sampled at acceptance; changing mode mid-stream SHALL NOT alter a result already registered.
REQ-027 Simultaneous consume and accept in one cycle SHALL replace the output register with the new result; out_valid stays 1.

Reset
REQ-028 While rst_n=0: out_valid=0, out_idx=0, out_zero=0, out_multi=0, multi_cnt=0, rr_ptr=0.
REQ-029 Reset asserted mid-transfer SHALL discard the held result; no partial state survives.
REQ-030 in_ready SHALL read 1 during and immediately after reset (derives from out_valid=0).

Structure
REQ-031 A shared package SHALL hold the mode encoding constants (MODE_FIXED=0, MODE_RR=1).
REQ-032 The combinational masked-search logic SHALL be one sub-module, rr_find_first (inputs vector, start pointer; outputs index, found), instantiated once.
REQ-033 All registers SHALL reside in rr_priority_encoder; rr_find_first SHALL be purely combinational.

Verification
REQ-034 N=8, mode=0, req=8'b0010_0100, out_ready=1 -> next cycle out_idx=2, out_multi=1, multi_cnt=1.
REQ-035 N=8, mode=1, req=8'hFF held for 10 back-to-back transfers -> out_idx sequence 0,1,...,7,0,1; in_ready constantly 1.
REQ-036 N=5, mode=1, rr_ptr=4, req=5'b00011 -> out_idx=0 (wrap), rr_ptr becomes 1.
REQ-037 req=0 accepted -> out_zero=1, out_idx=0, rr_ptr unchanged; out_ready=0 for 3 cycles -> in_ready=0 and out_* stable throughout.
REQ-038 CNT_W=2, five multi-hot vectors accepted -> multi_cnt sequence 1,2,3,3,3.
REQ-039 rst_n pulled low while out_valid=1 and out_ready=0 -> out_valid=0, multi_cnt=0, rr_ptr=0 asynchronously, before the next clock edge.
